// File: rtl/hwt_pkg.sv
// Shared types and constants for the hwt evaluation arbiter.
package hwt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      RESP
   } state_t;

   localparam int A_BIT = 0;
   localparam int B_BIT = 1;
   localparam int C_BIT = 2;
   localparam int D_BIT = 3;

   localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/hwt.sv
// Combinational hwt evaluation cell.
module hwt (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic y
);

   assign y = d & (c | (a & b)) & ~(a & b & c);

endmodule

// File: rtl/hwt_rr_pick.sv
// Round-robin picker: first request above ptr, wrapping to the lowest.
module hwt_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any_req
);

   logic hi;
   logic lo;
   int   hi_sel;
   int   lo_sel;
   int   sel;

   always_comb begin
      hi     = 1'b0;
      lo     = 1'b0;
      hi_sel = 0;
      lo_sel = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !lo) begin
            lo     = 1'b1;
            lo_sel = i;
         end
         if (req[i] && !hi && i > int'(ptr)) begin
            hi     = 1'b1;
            hi_sel = i;
         end
      end
      sel     = hi ? hi_sel : lo_sel;
      any_req = lo;
      idx     = ID_W'(sel);
      gnt     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = lo && (sel == i);
      end
   end

endmodule

// File: rtl/hwt_eval_arbiter.sv
// Round-robin arbiter sharing one hwt cell between NUM_REQ requesters.
module hwt_eval_arbiter
   import hwt_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_y,
   output logic                 busy,
   output logic [CNT_W-1:0]     hit_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t               state;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      id_reg;
   logic [3:0]           op_reg;
   logic                 y_reg;
   logic                 y_cell;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [ID_W-1:0]      pick_idx;
   logic                 pick_any;
   logic [3:0]           pick_op;

   hwt_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (pick_gnt),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   // only the granted slice is muxed, so X on idle requesters stays out
   always_comb begin
      pick_op = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) pick_op = req_data[4*i +: 4];
      end
   end

   hwt u_hwt (
      .a (op_reg[A_BIT]),
      .b (op_reg[B_BIT]),
      .c (op_reg[C_BIT]),
      .d (op_reg[D_BIT]),
      .y (y_cell)
   );

   assign req_ready = (rst_n && state == IDLE) ? pick_gnt : '0;
   assign rsp_id    = id_reg;
   assign rsp_y     = y_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= ID_W'(NUM_REQ - 1);
         id_reg    <= '0;
         op_reg    <= '0;
         y_reg     <= 1'b0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         hit_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  op_reg <= pick_op;
                  id_reg <= pick_idx;
                  busy   <= 1'b1;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               y_reg     <= y_cell;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  ptr       <= id_reg;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
                  if (y_reg && hit_count != CNT_MAX)
                     hit_count <= hit_count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
